// File: rtl/mine_neighbor_counter_pkg.sv
// Shared Buscaminas definitions: board geometry, bomb marker, cell count type, scan FSM states.
package buscaminas_pkg;

    localparam int          BOARD_N   = 8;
    localparam int          CELLS     = BOARD_N * BOARD_N;
    localparam int          IDX_W     = $clog2(CELLS);
    localparam int          RC_W      = $clog2(BOARD_N);
    localparam logic [3:0]  BOMB_CODE = 4'd9;

    // 0..8 neighbour count, or BOMB_CODE for a bomb cell
    typedef logic [3:0] cell_count_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/mine_neighbor_counter_if.sv
// Request/result bundle between the bomb placer side (master) and the neighbour counter (slave).
interface mine_neighbor_counter_if
    import buscaminas_pkg::*;
#(
    parameter int N = BOARD_N
) ();

    logic                           start;
    logic [N-1:0][N-1:0]            bomb_matrix;
    logic                           busy;
    logic                           done;
    logic                           valid;
    cell_count_t [N-1:0][N-1:0]     count_matrix;
    logic [$clog2(N*N):0]           bomb_total;

    modport master (
        output start, bomb_matrix,
        input  busy, done, valid, count_matrix, bomb_total
    );

    modport slave (
        input  start, bomb_matrix,
        output busy, done, valid, count_matrix, bomb_total
    );

endinterface

// File: rtl/mine_neighbor_counter_cell.sv
// Combinational neighbour count for one cell; neighbours off the board count as empty (no wrap).
module mine_cell_count
    import buscaminas_pkg::*;
#(
    parameter int N    = BOARD_N,
    parameter int RC_N = $clog2(N)
) (
    input  logic [N-1:0][N-1:0] snapshot,
    input  logic [RC_N-1:0]     row,
    input  logic [RC_N-1:0]     col,
    output cell_count_t         count
);

    int r;
    int c;

    // Sum the 8 surrounding cells, masking out coordinates that fall off any edge
    always_comb begin
        count = '0;
        r     = 0;
        c     = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(row) + dr;
                c = int'(col) + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < N && c >= 0 && c < N)
                    count = count + cell_count_t'(snapshot[r[RC_N-1:0]][c[RC_N-1:0]]);
            end
        end
    end

endmodule

// File: rtl/mine_neighbor_counter.sv
// Builds the per-cell adjacency map from a snapshotted bomb map, one cell per clock,
// and accumulates the total bomb count alongside.
module mine_neighbor_counter
    import buscaminas_pkg::*;
#(
    parameter int          BOARD_N   = buscaminas_pkg::BOARD_N,
    parameter cell_count_t BOMB_CODE = buscaminas_pkg::BOMB_CODE
) (
    input  logic                    clk,
    input  logic                    reset,
    mine_neighbor_counter_if.slave  bus
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int RC_W  = $clog2(BOARD_N);

    scan_state_t                        state, state_nxt;
    logic                               busy, done;
    logic                               last_cell;

    logic [IDX_W-1:0]                   idx;
    logic [RC_W-1:0]                    row, col;
    logic [BOARD_N-1:0][BOARD_N-1:0]    snapshot;
    cell_count_t [BOARD_N-1:0][BOARD_N-1:0] count_q;
    logic [IDX_W:0]                     total_q;
    logic                               valid_q;
    cell_count_t                        nb_count;
    cell_count_t                        cell_val;

    // Cell coordinates from the linear scan index (a shift/mask for power-of-two boards)
    assign row       = RC_W'(idx / IDX_W'(BOARD_N));
    assign col       = RC_W'(idx % IDX_W'(BOARD_N));
    assign last_cell = (idx == IDX_W'(CELLS - 1));

    mine_cell_count #(
        .N    (BOARD_N),
        .RC_N (RC_W)
    ) u_cell (
        .snapshot (snapshot),
        .row      (row),
        .col      (col),
        .count    (nb_count)
    );

    assign cell_val = snapshot[row][col] ? BOMB_CODE : nb_count;

    // State register; reset aborts any scan in progress
    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (last_cell)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Snapshot, per-cell write-back, bomb total and result-valid flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx      <= '0;
            snapshot <= '0;
            count_q  <= '0;
            total_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    snapshot <= bus.bomb_matrix;
                    count_q  <= '0;
                    total_q  <= '0;
                    valid_q  <= 1'b0;
                    idx      <= '0;
                end
                S_SCAN: begin
                    count_q[row][col] <= cell_val;
                    total_q           <= total_q + (IDX_W+1)'(snapshot[row][col]);
                    idx               <= idx + 1'b1;
                    // results are complete once the last cell lands, so valid covers DONE too
                    if (last_cell)
                        valid_q <= 1'b1;
                end
                S_DONE: begin
                    valid_q <= 1'b1;
                    idx     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.valid        = valid_q;
    assign bus.count_matrix = count_q;
    assign bus.bomb_total   = total_q;

endmodule

// File: tb/tb_mine_neighbor_counter.sv
// Scoreboard bench: the driver pushes reference results per scan; a monitor pops them on done.
module tb_mine_neighbor_counter;
    import buscaminas_pkg::*;

    localparam int N = 8;

    typedef logic [N-1:0][N-1:0]      board_t;
    typedef logic [N-1:0][N-1:0][3:0] cmap_t;
    typedef struct {
        cmap_t cm;
        int    total;
        int    start_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mine_neighbor_counter_if ifc ();

    mine_neighbor_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    exp_t sb_q[$];
    int   pass_cnt     = 0;
    int   total_cnt    = 0;
    int   cyc          = 0;
    int   done_seen    = 0;
    int   scans_issued = 0;
    logic prev_done    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: minesweeper adjacency straight from the board, with plain bounds tests
    function automatic void ref_model(input board_t b, output cmap_t cm, output int total);
        total = 0;
        cm    = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (b[r[2:0]][c[2:0]]) begin
                    cm[r[2:0]][c[2:0]] = 4'd9;
                    total++;
                end else begin
                    int s;
                    s = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            int rr, cc;
                            rr = r + dr;
                            cc = c + dc;
                            if ((dr != 0 || dc != 0) && rr >= 0 && rr < N && cc >= 0 && cc < N)
                                s += int'(b[rr[2:0]][cc[2:0]]);
                        end
                    cm[r[2:0]][c[2:0]] = s[3:0];
                end
            end
        end
    endfunction

    // Monitor: compare against the oldest outstanding expectation whenever done pulses
    always @(negedge clk) begin
        if (reset) begin
            if (ifc.done) begin
                done_seen++;
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got done=1 expected no pending scan");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("count_matrix", ifc.count_matrix, e.cm);
                    check("bomb_total", 256'(ifc.bomb_total), 256'(e.total));
                    check("done_latency", 256'(cyc - e.start_cyc), 256'(66));
                end
            end
            if (prev_done) check("valid_after_done", 256'(ifc.valid), 256'(1));
        end
        prev_done <= ifc.done;
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!ifc.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.done) begin
            total_cnt++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    task automatic run_scan(input board_t b, input bit disturb);
        cmap_t cm;
        int    t;
        exp_t  e;
        ref_model(b, cm, t);
        @(negedge clk);
        ifc.bomb_matrix = b;
        ifc.start       = 1'b1;
        e.cm = cm; e.total = t; e.start_cyc = cyc;
        sb_q.push_back(e);
        scans_issued++;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_mid_scan", 256'(ifc.busy), 256'(1));
        check("valid_mid_scan", 256'(ifc.valid), 256'(0));
        if (disturb) begin
            ifc.start       = 1'b1;
            ifc.bomb_matrix = ~b;
            @(negedge clk);
            ifc.start = 1'b0;
        end
        wait_done();
        repeat (4) @(negedge clk);
        check("idle_hold_matrix", ifc.count_matrix, cm);
        check("idle_busy", 256'(ifc.busy), 256'(0));
    endtask

    initial begin
        board_t b;
        ifc.start       = 1'b0;
        ifc.bomb_matrix = '0;
        reset           = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(ifc.busy), 256'(0));
        check("rst_done", 256'(ifc.done), 256'(0));
        check("rst_valid", 256'(ifc.valid), 256'(0));
        check("rst_matrix", ifc.count_matrix, 256'(0));
        check("rst_total", 256'(ifc.bomb_total), 256'(0));
        reset = 1'b1;

        // empty board
        b = '0;
        run_scan(b, 1'b0);
        // corner bomb, no wrap-around
        b = '0; b[0][0] = 1'b1;
        run_scan(b, 1'b0);
        // interior bomb
        b = '0; b[3][3] = 1'b1;
        run_scan(b, 1'b0);
        // two bombs on the bottom edge
        b = '0; b[7][6] = 1'b1; b[7][7] = 1'b1;
        run_scan(b, 1'b0);
        // full board
        b = '1;
        run_scan(b, 1'b0);
        // checkerboard
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[r[2:0]][c[2:0]] = ((r + c) % 2 == 1);
        run_scan(b, 1'b0);
        // start and bomb_matrix disturbed mid-scan
        for (int k = 0; k < N * N; k++) b[k / N][k % N] = ($urandom_range(99) < 30);
        run_scan(b, 1'b1);
        repeat (5) @(negedge clk);
        check("single_done_after_disturb", 256'(done_seen), 256'(scans_issued));

        // reset in the middle of a scan
        @(negedge clk);
        ifc.bomb_matrix = '1;
        ifc.start       = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midscan_rst_busy", 256'(ifc.busy), 256'(0));
        check("midscan_rst_valid", 256'(ifc.valid), 256'(0));
        check("midscan_rst_done", 256'(ifc.done), 256'(0));
        check("midscan_rst_matrix", ifc.count_matrix, 256'(0));
        reset = 1'b1;

        // randomized boards of varying density
        for (int i = 0; i < 8; i++) begin
            int dens;
            dens = $urandom_range(90, 5);
            for (int k = 0; k < N * N; k++) b[k / N][k % N] = ($urandom_range(99) < dens);
            run_scan(b, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("done_count", 256'(done_seen), 256'(scans_issued));
        check("scoreboard_empty", 256'(sb_q.size()), 256'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
